// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter for the user-port audio link.
// A stereo PCM pair is accepted over a valid/ready handshake into a one-deep holding
// register, then serialised MSB-first with WS leading the data by one BCLK.
// Data and WS change on BCLK falling edges so the sink can sample on rising edges.
module i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 16,
  parameter int SLOT    = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             i2s_bclk,
  output logic             i2s_ws,
  output logic             i2s_data,
  output logic             frame_start,
  output logic             underrun
);

  localparam int FRAME_BITS = 2 * SLOT;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int DW         = $clog2(CLK_DIV + 1);

  localparam logic [BW-1:0]    B_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0]    B_ONE    = BW'(1);
  localparam logic [BW-1:0]    SLOT_B   = BW'(SLOT);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_pos;
  logic [BW-1:0]    pos_next;
  logic [BW-1:0]    pos_after;
  logic [BW-1:0]    slot_idx;
  logic [WIDTH-1:0] hold_left;
  logic [WIDTH-1:0] hold_right;
  logic [WIDTH-1:0] frame_left;
  logic [WIDTH-1:0] frame_right;
  logic [WIDTH-1:0] src_left;
  logic [WIDTH-1:0] src_right;
  logic [WIDTH-1:0] chan_sample;
  logic             hold_full;
  logic             hold_full_next;
  logic             div_term;
  logic             bclk_fall;
  logic             frame_load;
  logic             write_en;
  logic             data_next;
  logic             ws_next;

  // A falling edge happens on the divider terminal count while BCLK is high; the last
  // position of a frame wrapping to 0 is the frame-load point.
  assign div_term   = (div_cnt == DIV_LAST);
  assign bclk_fall  = en & div_term & i2s_bclk;
  assign pos_next   = (bit_pos == B_LAST) ? '0 : bit_pos + B_ONE;
  assign frame_load = bclk_fall & (bit_pos == B_LAST);
  assign write_en   = in_valid & in_ready;

  // The load drains the holding register before a same-cycle write can refill it.
  assign hold_full_next = (hold_full & ~frame_load) | write_en;

  // On a load the outgoing MSB must come from the incoming frame, not the stale one.
  assign src_left  = (frame_load && hold_full) ? hold_left  : frame_left;
  assign src_right = (frame_load && hold_full) ? hold_right : frame_right;

  // Pick the bit for the next position; slot indices past WIDTH shift out to pad zeros.
  always_comb begin
    pos_after   = '0;
    slot_idx    = '0;
    chan_sample = '0;
    data_next   = 1'b0;
    ws_next     = 1'b0;
    pos_after   = (pos_next == B_LAST) ? '0 : pos_next + B_ONE;
    if (pos_next >= SLOT_B) begin
      chan_sample = src_right;
      slot_idx    = pos_next - SLOT_B;
    end else begin
      chan_sample = src_left;
      slot_idx    = pos_next;
    end
    data_next = |(chan_sample & (MSB_MASK >> slot_idx));
    ws_next   = (pos_after >= SLOT_B);
  end

  // BCLK divider: idling clears it so the first edge after enable is always rising.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_term) begin
      div_cnt  <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_cnt  <= div_cnt + DIV_ONE;
    end
  end

  // Serialiser: advance the bit position, drive data/WS and load frames on falling edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_pos     <= B_LAST;
      i2s_data    <= 1'b0;
      i2s_ws      <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (!en) begin
        bit_pos  <= B_LAST;
        i2s_data <= 1'b0;
        i2s_ws   <= 1'b0;
      end else if (bclk_fall) begin
        bit_pos  <= pos_next;
        i2s_data <= data_next;
        i2s_ws   <= ws_next;
        if (frame_load) begin
          frame_left  <= src_left;
          frame_right <= src_right;
          frame_start <= 1'b1;
          underrun    <= ~hold_full;
        end
      end
    end
  end

  // Holding register and handshake; keeps accepting while the link is idle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_left  <= '0;
      hold_right <= '0;
      hold_full  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (write_en) begin
        hold_left  <= in_left;
        hold_right <= in_right;
      end
      hold_full <= hold_full_next;
      in_ready  <= ~hold_full_next;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized and directed bench for i2s_tx with a frame-level reference model.
// The model derives every output from the number of enabled cycles since restart.
module tb_i2s_tx;

  localparam int CD = 2;
  localparam int W  = 16;
  localparam int S  = 16;
  localparam int S2 = 24;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic         en;
  logic         in_valid;
  logic [W-1:0] in_left;
  logic [W-1:0] in_right;
  logic         in_ready;
  logic         i2s_bclk;
  logic         i2s_ws;
  logic         i2s_data;
  logic         frame_start;
  logic         underrun;

  logic         en2;
  logic         valid2;
  logic [W-1:0] left2;
  logic [W-1:0] right2;
  logic         ready2;
  logic         bclk2;
  logic         ws2;
  logic         data2;
  logic         fs2;
  logic         ur2;

  int checkCount = 0;
  int errorCount = 0;

  // reference model state
  int           t;
  bit           mFull;
  bit           mReady;
  bit           expFs;
  bit           expUr;
  logic [W-1:0] holdL;
  logic [W-1:0] holdR;
  logic [W-1:0] frameL;
  logic [W-1:0] frameR;

  // observation bookkeeping
  int cycleNum;
  int urCount;
  bit prevBclk;
  bit capWs[$];
  bit capData[$];
  int fsCycles[$];
  int acceptCycles[$];

  always #5 clk_sys = ~clk_sys;

  i2s_tx #(.CLK_DIV(CD), .WIDTH(W), .SLOT(S)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .en          (en),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_ws      (i2s_ws),
    .i2s_data    (i2s_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  i2s_tx #(.CLK_DIV(CD), .WIDTH(W), .SLOT(S2)) dut24 (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .en          (en2),
    .in_left     (left2),
    .in_right    (right2),
    .in_valid    (valid2),
    .in_ready    (ready2),
    .i2s_bclk    (bclk2),
    .i2s_ws      (ws2),
    .i2s_data    (data2),
    .frame_start (fs2),
    .underrun    (ur2)
  );

  task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    t      = 0;
    mFull  = 1'b0;
    mReady = 1'b1;
    expFs  = 1'b0;
    expUr  = 1'b0;
    holdL  = '0;
    holdR  = '0;
    frameL = '0;
    frameR = '0;
  endtask

  // One clock edge of the model: frame loads happen on every (2*SLOT)-th falling edge,
  // the load drains the holding slot before a same-edge write refills it.
  task automatic modelEdge();
    bit accept;
    bit load;
    if (!reset_n) begin
      modelReset();
      return;
    end
    accept = in_valid && mReady;
    load   = 1'b0;
    expFs  = 1'b0;
    expUr  = 1'b0;
    if (en) begin
      t++;
      if ((t % (2 * CD)) == 0 && ((t / (2 * CD) - 1) % (2 * S)) == 0) load = 1'b1;
    end else begin
      t = 0;
    end
    if (load) begin
      expFs = 1'b1;
      if (mFull) begin
        frameL = holdL;
        frameR = holdR;
        mFull  = 1'b0;
      end else begin
        expUr = 1'b1;
      end
    end
    if (accept) begin
      holdL = in_left;
      holdR = in_right;
      mFull = 1'b1;
    end
    mReady = !mFull;
  endtask

  // Expected {bclk, ws, data, ready, frame_start, underrun} from elapsed enabled cycles.
  function automatic logic [5:0] expectedOutputs();
    int           n;
    int           p;
    int           k;
    logic [W-1:0] smp;
    bit           b;
    bit           w;
    bit           d;
    b = ((t / CD) % 2) == 1;
    n = t / (2 * CD);
    w = 1'b0;
    d = 1'b0;
    if (n > 0) begin
      p   = (n - 1) % (2 * S);
      smp = (p >= S) ? frameR : frameL;
      k   = p % S;
      if (k < W) d = smp[W-1-k];
      w = ((p + 1) % (2 * S)) >= S;
    end
    return {b, w, d, mReady, expFs, expUr};
  endfunction

  function automatic bit inRightSlot();
    int n;
    int p;
    n = t / (2 * CD);
    if (n == 0) return 1'b0;
    p = (n - 1) % (2 * S);
    return (p >= S + 4) && (p <= S + 10);
  endfunction

  task automatic applyStimulus(input bit v, input logic [W-1:0] l, input logic [W-1:0] r, input bit e);
    in_valid = v;
    in_left  = l;
    in_right = r;
    en       = e;
  endtask

  task automatic stepCycle();
    bit accNow;
    accNow = in_valid && in_ready;
    @(posedge clk_sys);
    modelEdge();
    cycleNum++;
    if (accNow) acceptCycles.push_back(cycleNum);
    @(negedge clk_sys);
    checkOutput("outputs{bclk,ws,data,ready,fs,ur}",
                48'({i2s_bclk, i2s_ws, i2s_data, in_ready, frame_start, underrun}),
                48'(expectedOutputs()));
    if (i2s_bclk && !prevBclk) begin
      capWs.push_back(i2s_ws);
      capData.push_back(i2s_data);
    end
    prevBclk = i2s_bclk;
    if (frame_start) fsCycles.push_back(cycleNum);
    if (underrun) urCount++;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_values", 48'({i2s_bclk, i2s_ws, i2s_data, in_ready, frame_start, underrun}),
                48'(6'b000100));
    repeat (2) stepCycle();
    reset_n  = 1'b1;
    cycleNum = 0;
    urCount  = 0;
    prevBclk = 1'b0;
    fsCycles.delete();
    acceptCycles.delete();
    capWs.delete();
    capData.delete();
  endtask

  initial begin
    logic [15:0] l0;
    logic [15:0] r0;
    logic [15:0] l1;
    logic [15:0] r1;
    logic [31:0] wsPat;
    logic [23:0] wl;
    logic [23:0] wr;
    logic [23:0] wsl;
    logic [23:0] wsr;
    logic [15:0] r2;
    int          nAcc;
    int          rnd;
    int          fs2Count;
    int          ur2Count;
    bit          enState;
    bit          p2;
    bit          w2q[$];
    bit          d2q[$];

    reset_n = 1'b1;
    en2     = 1'b0;
    valid2  = 1'b0;
    left2   = '0;
    right2  = '0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    cycleNum = 0;
    urCount  = 0;
    prevBclk = 1'b0;
    modelReset();
    @(negedge clk_sys);

    // one pair then nothing: serial words, WS lead, retransmit and frame spacing
    doReset();
    checkOutput("slot24_ready_after_reset", 48'(ready2), 48'(1));
    applyStimulus(1'b1, 16'h8001, 16'h7FFE, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    repeat (299) stepCycle();
    checkOutput("capture_count_ok", 48'(capData.size() >= 65), 48'(1));
    if (capData.size() >= 65) begin
      for (int i = 0; i < 16; i++) begin
        l0 = {l0[14:0], capData[1+i]};
        r0 = {r0[14:0], capData[17+i]};
        l1 = {l1[14:0], capData[33+i]};
        r1 = {r1[14:0], capData[49+i]};
      end
      for (int i = 0; i < 32; i++) wsPat = {wsPat[30:0], capWs[1+i]};
      checkOutput("left_word", 48'(l0), 48'(16'h8001));
      checkOutput("right_word", 48'(r0), 48'(16'h7FFE));
      checkOutput("ws_pattern", 48'(wsPat), 48'(32'h0001_FFFE));
      checkOutput("repeat_left_word", 48'(l1), 48'(16'h8001));
      checkOutput("repeat_right_word", 48'(r1), 48'(16'h7FFE));
    end
    checkOutput("frame_count", 48'(fsCycles.size()), 48'(3));
    if (fsCycles.size() >= 3) begin
      checkOutput("first_frame_cycle", 48'(fsCycles[0]), 48'(2 * CD));
      checkOutput("frame_spacing_1", 48'(fsCycles[1] - fsCycles[0]), 48'(128));
      checkOutput("frame_spacing_2", 48'(fsCycles[2] - fsCycles[1]), 48'(128));
    end
    checkOutput("underrun_count", 48'(urCount), 48'(2));

    // in_valid held high: one accept per frame and no underruns
    doReset();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    for (int c = 0; c < 700; c++) begin
      stepCycle();
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    end
    checkOutput("streaming_underruns", 48'(urCount), 48'(0));
    checkOutput("streaming_frames", 48'(fsCycles.size()), 48'(6));
    checkOutput("streaming_accepts", 48'(acceptCycles.size()), 48'(7));
    if (acceptCycles.size() > 0) checkOutput("first_accept_cycle", 48'(acceptCycles[0]), 48'(1));
    for (int i = 0; i + 1 < fsCycles.size(); i++) begin
      nAcc = 0;
      foreach (acceptCycles[j])
        if (acceptCycles[j] >= fsCycles[i] && acceptCycles[j] < fsCycles[i+1]) nAcc++;
      checkOutput($sformatf("accepts_in_frame%0d", i), 48'(nAcc), 48'(1));
    end

    // reset in the middle of the right slot, then restart timing
    for (int c = 0; c < 200; c++) begin
      stepCycle();
      if (inRightSlot()) break;
    end
    checkOutput("reached_right_slot", 48'(inRightSlot()), 48'(1));
    doReset();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    repeat (19) stepCycle();
    checkOutput("restart_first_frame", 48'((fsCycles.size() > 0) ? fsCycles[0] : -1), 48'(2 * CD));
    checkOutput("restart_underruns", 48'(urCount), 48'(0));

    // drop en for 10 cycles mid-frame while pushing a pair into the idle link
    repeat (40) stepCycle();
    applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (9) stepCycle();
    checkOutput("idle_link_outputs", 48'({i2s_bclk, i2s_ws, i2s_data}), 48'(0));
    checkOutput("idle_pair_held", 48'(in_ready), 48'(0));
    applyStimulus(1'b0, '0, '0, 1'b1);
    cycleNum = 0;
    urCount  = 0;
    fsCycles.delete();
    repeat (20) stepCycle();
    checkOutput("en_restart_first_frame", 48'((fsCycles.size() > 0) ? fsCycles[0] : -1), 48'(2 * CD));
    checkOutput("en_restart_underruns", 48'(urCount), 48'(0));

    // randomized traffic with occasional idles and resets
    enState = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rnd = int'($urandom_range(0, 999));
      if (rnd < 2) doReset();
      if (enState) begin
        if (rnd >= 996) enState = 1'b0;
      end else begin
        if ((rnd % 8) == 0) enState = 1'b1;
      end
      applyStimulus($urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom), enState);
      stepCycle();
    end

    // SLOT=24 instance: pad bits after the 16-bit sample, WS spans the whole slot
    doReset();
    checkOutput("slot24_ready_idle", 48'(ready2), 48'(1));
    r2     = 16'($urandom);
    en2    = 1'b1;
    valid2 = 1'b1;
    left2  = 16'hFFFF;
    right2 = r2;
    p2       = 1'b0;
    fs2Count = 0;
    ur2Count = 0;
    for (int c = 0; c < 300 && d2q.size() < 49; c++) begin
      @(negedge clk_sys);
      if (c == 0) valid2 = 1'b0;
      if (bclk2 && !p2) begin
        w2q.push_back(ws2);
        d2q.push_back(data2);
      end
      p2 = bclk2;
      if (fs2) fs2Count++;
      if (ur2) ur2Count++;
    end
    checkOutput("slot24_captures", 48'(d2q.size()), 48'(49));
    if (d2q.size() >= 49) begin
      for (int i = 0; i < 24; i++) begin
        wl  = {wl[22:0], d2q[1+i]};
        wr  = {wr[22:0], d2q[25+i]};
        wsl = {wsl[22:0], w2q[1+i]};
        wsr = {wsr[22:0], w2q[25+i]};
      end
      checkOutput("slot24_left_bits", 48'(wl), 48'(24'hFFFF00));
      checkOutput("slot24_right_bits", 48'(wr), 48'({r2, 8'h00}));
      checkOutput("slot24_ws_left", 48'(wsl), 48'(24'h000001));
      checkOutput("slot24_ws_right", 48'(wsr), 48'(24'hFFFFFE));
    end
    checkOutput("slot24_frame_starts", 48'(fs2Count), 48'(1));
    checkOutput("slot24_underruns", 48'(ur2Count), 48'(0));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
